inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with one outstanding memory request and redirect kill
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFID_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        IF_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic        kill;
    logic        kill_nxt;
    logic        load_buf;
    logic        clear_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic [31:0] target_pc;
    logic        accept;

    assign target_pc = {branch_target[31:2], 2'b00};
    assign accept    = imem_req && imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect always wins over delivering or advancing; a response already in
    // flight when the redirect arrives is swallowed via the kill flag.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        kill_nxt     = kill;
        load_buf     = 1'b0;
        clear_valid  = 1'b0;
        case (state)
            S_REQ: begin
                if (branch_taken) begin
                    fetch_pc_nxt = target_pc;
                end else if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    fetch_pc_nxt = target_pc;
                    if (imem_rvalid) begin
                        state_nxt = S_REQ;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_nxt = kill ? S_REQ : S_HOLD;
                    kill_nxt  = 1'b0;
                    load_buf  = !kill;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    fetch_pc_nxt = target_pc;
                    clear_valid  = 1'b1;
                    state_nxt    = S_REQ;
                end else if (IFID_write) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    clear_valid  = 1'b1;
                    state_nxt    = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_comb begin
        imem_req    = reset && (state == S_REQ) && !branch_taken;
        imem_addr   = {fetch_pc[31:2], 2'b00};
        instruction = IF_valid ? buf_inst : NOP_INST;
        pc          = IF_valid ? buf_pc : 32'h0000_0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
            IF_valid <= 1'b0;
            buf_inst <= NOP_INST;
            buf_pc   <= 32'h0000_0000;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            kill     <= kill_nxt;
            if (load_buf) begin
                buf_inst <= imem_rdata;
                buf_pc   <= fetch_pc;
                IF_valid <= 1'b1;
            end else if (clear_valid) begin
                IF_valid <= 1'b0;
            end
        end
    end

endmodule
